// File: rtl/tx_queue_manager_pkg.sv
// Shared constants and types for the TX queue manager: ring pointer width,
// per-queue ring state and the issue FSM encoding.
package tx_queue_manager_pkg;

  localparam int PTR_W             = 26;
  localparam int DEF_MAX_REQ_FLITS = 64;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    ptr_t tail;
    ptr_t issue_head;
    ptr_t done_head;
  } txq_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit after 'last', wrapping.
// Returns a one-hot grant, its index and whether anything was requesting.
module rr_arbiter #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // N is a power of two, so the IW-bit add wraps the search around the ring.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last + IW'(i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/tx_queue_manager.sv
// Per-queue TX ring tracker: turns software tail doorbells into ring-bounded DMA read
// requests (2 cycles doorbell->req_valid) and reports completed heads back to software.
module tx_queue_manager
  import tx_queue_manager_pkg::*;
#(
  parameter  int NB_QUEUES       = 16,
  parameter  int MAX_REQ_FLITS   = DEF_MAX_REQ_FLITS,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int QW              = $clog2(NB_QUEUES),
  localparam int FW              = $clog2(MAX_REQ_FLITS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tail_wr_valid,
  input  logic [QW-1:0] tail_wr_queue,
  input  logic [25:0]   tail_wr_value,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [QW-1:0] req_queue,
  output logic [25:0]   req_offset,
  output logic [FW-1:0] req_flits,
  input  logic          cpl_valid,
  output logic          cpl_ready,
  input  logic [QW-1:0] cpl_queue,
  input  logic [FW-1:0] cpl_flits,
  output logic          head_wb_valid,
  input  logic          head_wb_ready,
  output logic [QW-1:0] head_wb_queue,
  output logic [25:0]   head_wb_value,
  input  logic [25:0]   rb_size,
  output logic [31:0]   bad_tail_cnt
);

  localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam ptr_t          MAX_FL  = ptr_t'(MAX_REQ_FLITS);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  txq_state_t           q_st [NB_QUEUES];
  state_t               state, state_nxt;
  logic [OW-1:0]        outstanding;
  logic [QW-1:0]        last_granted;
  logic [NB_QUEUES-1:0] pending, gnt;
  logic [QW-1:0]        gnt_idx;
  logic                 gnt_any, load_req, db_ok, db_go, issue_fire, cpl_fire;
  ptr_t                 mask, sel_tail, sel_head, avail, room, flits_calc, done_nxt;

  assign mask       = rb_size - ptr_t'(1);
  assign db_ok      = tail_wr_value < rb_size;
  assign db_go      = tail_wr_valid && db_ok && (tail_wr_value != q_st[tail_wr_queue].issue_head);
  assign req_valid  = (state == ISSUE);
  assign issue_fire = req_valid && req_ready;
  assign cpl_ready  = !head_wb_valid || head_wb_ready;
  assign cpl_fire   = cpl_valid && cpl_ready;
  assign done_nxt   = (q_st[cpl_queue].done_head + ptr_t'(cpl_flits)) & mask;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NB_QUEUES; i++) pending[i] = (q_st[i].tail != q_st[i].issue_head);
  end

  rr_arbiter #(.N(NB_QUEUES)) u_rr (
    .req  (pending),
    .last (last_granted),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Request size: bounded by data available, max burst and distance to the ring end.
  always_comb begin
    sel_tail = '0;
    sel_head = '0;
    for (int i = 0; i < NB_QUEUES; i++) begin
      if (gnt[i]) begin
        sel_tail |= q_st[i].tail;
        sel_head |= q_st[i].issue_head;
      end
    end
    avail      = (sel_tail - sel_head) & mask;
    room       = rb_size - sel_head;
    flits_calc = avail;
    if (MAX_FL < flits_calc) flits_calc = MAX_FL;
    if (room < flits_calc)   flits_calc = room;
  end

  // IDLE also reacts to a doorbell arriving this cycle to reach req_valid in 2 cycles.
  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      IDLE:  if ((|pending) || db_go) state_nxt = ARB;
      ARB: begin
        if (!gnt_any) begin
          state_nxt = IDLE;
        end else if (outstanding < MAX_OUT) begin
          state_nxt = ISSUE;
          load_req  = 1'b1;
        end
      end
      ISSUE: if (req_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_QUEUES; i++) q_st[i] <= '0;
    end else begin
      if (tail_wr_valid && db_ok) q_st[tail_wr_queue].tail <= tail_wr_value;
      if (issue_fire) q_st[req_queue].issue_head <= (req_offset + ptr_t'(req_flits)) & mask;
      if (cpl_fire)   q_st[cpl_queue].done_head  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      outstanding  <= '0;
      last_granted <= '0;
      req_queue    <= '0;
      req_offset   <= '0;
      req_flits    <= '0;
      bad_tail_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_req) begin
        req_queue    <= gnt_idx;
        req_offset   <= sel_head;
        req_flits    <= FW'(flits_calc);
        last_granted <= gnt_idx;
      end
      case ({issue_fire, cpl_fire && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (tail_wr_valid && !db_ok && (bad_tail_cnt != '1)) bad_tail_cnt <= bad_tail_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_wb_valid <= 1'b0;
      head_wb_queue <= '0;
      head_wb_value <= '0;
    end else if (cpl_fire) begin
      head_wb_valid <= 1'b1;
      head_wb_queue <= cpl_queue;
      head_wb_value <= done_nxt;
    end else if (head_wb_ready) begin
      head_wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_queue_manager.sv
// Directed and randomized doorbell/issue/completion traffic against a ring-arithmetic
// reference model.
module tb_tx_queue_manager;

  localparam int NQ = 16;
  localparam int MF = 64;
  localparam int QW = 4;
  localparam int FW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tail_wr_valid = 1'b0;
  logic [QW-1:0] tail_wr_queue = '0;
  logic [25:0]   tail_wr_value = '0;
  logic          req_valid, req_ready = 1'b0;
  logic [QW-1:0] req_queue;
  logic [25:0]   req_offset;
  logic [FW-1:0] req_flits;
  logic          cpl_valid = 1'b0, cpl_ready;
  logic [QW-1:0] cpl_queue = '0;
  logic [FW-1:0] cpl_flits = '0;
  logic          head_wb_valid, head_wb_ready = 1'b1;
  logic [QW-1:0] head_wb_queue;
  logic [25:0]   head_wb_value;
  logic [25:0]   rb_size = 26'd1024;
  logic [31:0]   bad_tail_cnt;

  tx_queue_manager #(.NB_QUEUES(NQ), .MAX_REQ_FLITS(MF), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .tail_wr_valid(tail_wr_valid), .tail_wr_queue(tail_wr_queue), .tail_wr_value(tail_wr_value),
    .req_valid(req_valid), .req_ready(req_ready), .req_queue(req_queue),
    .req_offset(req_offset), .req_flits(req_flits),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_queue(cpl_queue), .cpl_flits(cpl_flits),
    .head_wb_valid(head_wb_valid), .head_wb_ready(head_wb_ready),
    .head_wb_queue(head_wb_queue), .head_wb_value(head_wb_value),
    .rb_size(rb_size), .bad_tail_cnt(bad_tail_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int m_tail [NQ];
  int m_issue[NQ];
  int m_done [NQ];
  int m_last, m_bad, m_out, rb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin
      m_tail[i] = 0; m_issue[i] = 0; m_done[i] = 0;
    end
    m_last = 0; m_bad = 0; m_out = 0;
  endtask

  function automatic int model_pick();
    for (int i = 1; i <= NQ; i++) begin
      int qq;
      qq = (m_last + i) % NQ;
      if (m_tail[qq] != m_issue[qq]) return qq;
    end
    return -1;
  endfunction

  function automatic int model_flits(input int q);
    int f;
    f = (m_tail[q] - m_issue[q] + rb) % rb;
    if (f > MF) f = MF;
    if (f > rb - m_issue[q]) f = rb - m_issue[q];
    return f;
  endfunction

  task automatic doorbell(input int q, input int v);
    tail_wr_valid = 1'b1; tail_wr_queue = QW'(q); tail_wr_value = 26'(v);
    tick();
    tail_wr_valid = 1'b0;
    if (v < rb) m_tail[q] = v; else m_bad++;
  endtask

  task automatic take_req(output int q, output int off, output int fl,
                          input bit db_en, input int db_q, input int db_v);
    bit ok;
    int eq, ef;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (req_valid) ok = 1'b1; else tick();
    end
    chk("req_appears", ok, 1);
    eq = model_pick();
    if (eq < 0) eq = 0;
    ef = model_flits(eq);
    q = int'(req_queue); off = int'(req_offset); fl = int'(req_flits);
    chk("req_queue", q, eq);
    chk("req_offset", off, m_issue[eq]);
    chk("req_flits", fl, ef);
    repeat ($urandom_range(0, 2)) tick();
    chk("req_hold_valid", req_valid, 1);
    chk("req_hold_offset", req_offset, m_issue[eq]);
    req_ready = 1'b1;
    if (db_en) begin
      tail_wr_valid = 1'b1; tail_wr_queue = QW'(db_q); tail_wr_value = 26'(db_v);
    end
    tick();
    req_ready = 1'b0;
    tail_wr_valid = 1'b0;
    if (db_en) begin
      if (db_v < rb) m_tail[db_q] = db_v; else m_bad++;
    end
    m_issue[eq] = (m_issue[eq] + ef) % rb;
    m_last = eq;
    m_out++;
  endtask

  task automatic complete(input int q, input int fl);
    bit ok;
    ok = 1'b0;
    cpl_valid = 1'b1; cpl_queue = QW'(q); cpl_flits = FW'(fl);
    for (int i = 0; i < 64 && !ok; i++) begin
      if (cpl_ready) ok = 1'b1; else tick();
    end
    chk("cpl_ready_seen", ok, 1);
    tick();
    cpl_valid = 1'b0;
    m_done[q] = (m_done[q] + fl) % rb;
    if (m_out > 0) m_out--;
    chk("wb_valid", head_wb_valid, 1);
    chk("wb_queue", head_wb_queue, q);
    chk("wb_value", head_wb_value, m_done[q]);
  endtask

  task automatic serve_one(output int q);
    int o, f;
    take_req(q, o, f, 1'b0, 0, 0);
    complete(q, f);
  endtask

  task automatic drain();
    int q;
    for (int k = 0; k < 300 && model_pick() >= 0; k++) serve_one(q);
    repeat (6) tick();
    chk("idle_after_drain", req_valid, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, o, f;
    rb = 1024;
    model_reset();

    #12;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_wb_valid", head_wb_valid, 0);
    chk("rst_bad_cnt", bad_tail_cnt, 0);
    chk("rst_req_flits", req_flits, 0);
    chk("rst_cpl_ready", cpl_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Round-robin order, then continuous doorbells on three queues.
    doorbell(1, 10); doorbell(2, 20); doorbell(7, 30);
    serve_one(q); chk("rr_first", q, 1);
    serve_one(q); chk("rr_second", q, 2);
    serve_one(q); chk("rr_third", q, 7);
    doorbell(1, 1000); doorbell(2, 200); doorbell(7, 100);
    drain();

    // Doorbell-to-request latency and burst splitting.
    doorbell(3, 100);
    chk("lat_cycle1", req_valid, 0);
    tick();
    chk("lat_cycle2", req_valid, 1);
    take_req(q, o, f, 1'b0, 0, 0);
    chk("q3_off0", o, 0); chk("q3_fl0", f, 64);
    complete(q, f);
    take_req(q, o, f, 1'b0, 0, 0);
    chk("q3_off1", o, 64); chk("q3_fl1", f, 36);
    complete(q, f);

    // Doorbell landing on the same queue in the handshake cycle.
    doorbell(3, 200);
    take_req(q, o, f, 1'b1, 3, 300);
    complete(q, f);
    drain();

    // Ring-end split.
    doorbell(5, 1000);
    drain();
    doorbell(5, 40);
    take_req(q, o, f, 1'b0, 0, 0);
    chk("wrap_off0", o, 1000); chk("wrap_fl0", f, 24);
    complete(q, f);
    take_req(q, o, f, 1'b0, 0, 0);
    chk("wrap_off1", o, 0); chk("wrap_fl1", f, 40);
    complete(q, f);

    // Outstanding limit and head write-back backpressure.
    doorbell(0, 640);
    for (int i = 0; i < 8; i++) take_req(q, o, f, 1'b0, 0, 0);
    repeat (8) tick();
    chk("limit_no_req", req_valid, 0);
    head_wb_ready = 1'b0;
    cpl_valid = 1'b1; cpl_queue = '0; cpl_flits = FW'(64);
    chk("bp_cpl_ready_first", cpl_ready, 1);
    tick();
    m_done[0] = 64; m_out--;
    chk("bp_wb_valid", head_wb_valid, 1);
    chk("bp_wb_value0", head_wb_value, 64);
    chk("bp_cpl_ready_blocked", cpl_ready, 0);
    take_req(q, o, f, 1'b0, 0, 0);
    chk("ninth_off", o, 512);
    chk("bp_wb_hold", head_wb_value, 64);
    head_wb_ready = 1'b1;
    tick();
    cpl_valid = 1'b0;
    m_done[0] = 128; m_out--;
    chk("bp_wb_valid2", head_wb_valid, 1);
    chk("bp_wb_value1", head_wb_value, 128);
    for (int i = 0; i < 7; i++) complete(0, 64);
    drain();

    // Out-of-range tail, then reset while a request is presented.
    doorbell(4, 2000);
    chk("bad_tail_cnt", bad_tail_cnt, m_bad);
    repeat (6) tick();
    chk("bad_tail_no_req", req_valid, 0);
    doorbell(4, 50);
    tick();
    chk("pre_reset_req", req_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_req_valid", req_valid, 0);
    chk("reset_req_offset", req_offset, 0);
    chk("reset_bad_cnt", bad_tail_cnt, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    doorbell(4, 0);
    repeat (8) tick();
    chk("no_replay_no_req", req_valid, 0);

    // Randomized batches on a smaller ring.
    rb = 256;
    rb_size = 26'd256;
    for (int b = 0; b < 25; b++) begin
      int k, base, stride, first;
      int qs[4];
      int vs[4];
      bit prod[4];
      k = $urandom_range(1, 4);
      base = $urandom_range(0, NQ - 1);
      stride = 2 * $urandom_range(0, 7) + 1;
      for (int i = 0; i < 4; i++) begin
        qs[i] = (base + i * stride) % NQ;
        vs[i] = ($urandom_range(0, 7) == 0) ? 256 + $urandom_range(0, 2000) : $urandom_range(0, 255);
        prod[i] = (i < k) && (vs[i] < rb) && (vs[i] != m_issue[qs[i]]);
      end
      first = -1;
      for (int j = 1; j <= NQ; j++) begin
        for (int i = 0; i < k; i++) begin
          if (first < 0 && prod[i] && qs[i] == (m_last + j) % NQ) first = i;
        end
      end
      for (int i = 0; i < k; i++) if (!prod[i]) doorbell(qs[i], vs[i]);
      if (first >= 0) doorbell(qs[first], vs[first]);
      for (int i = 0; i < k; i++) if (prod[i] && i != first) doorbell(qs[i], vs[i]);
      drain();
    end
    chk("rand_bad_cnt", bad_tail_cnt, m_bad);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_queue_manager.md
TX_QUEUE_MANAGER -- requirements
Module: tx_queue_manager

Interface
REQ-001 SHALL have parameter NB_QUEUES, default 16, meaning the number of TX queues (power of two, 2..64).
REQ-002 SHALL have parameter MAX_REQ_FLITS, default 64, meaning the maximum number of 64B flits per DMA read request.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum number of issued requests without a completion.
REQ-004 SHALL have ports: clk, input, 1, the single clock; rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports: tail_wr_valid, input, 1; tail_wr_queue, input, $clog2(NB_QUEUES); tail_wr_value, input, 26, a software doorbell carrying the new tail in flits.
REQ-006 SHALL have ports: req_valid, output, 1; req_ready, input, 1; req_queue, output, $clog2(NB_QUEUES); req_offset, output, 26 (ring offset in flits); req_flits, output, $clog2(MAX_REQ_FLITS)+1.
REQ-007 SHALL have ports: cpl_valid, input, 1; cpl_ready, output, 1; cpl_queue, input, $clog2(NB_QUEUES); cpl_flits, input, $clog2(MAX_REQ_FLITS)+1.
REQ-008 SHALL have ports: head_wb_valid, output, 1; head_wb_ready, input, 1; head_wb_queue, output, $clog2(NB_QUEUES); head_wb_value, output, 26, the completed head reported to software.
REQ-009 SHALL have ports: rb_size, input, 26, the ring size in flits (power of two, static while traffic is live); bad_tail_cnt, output, 32, a saturating error counter.

Function
REQ-010 SHALL keep per-queue registers tail, issue_head and done_head, each 26 bits, with all arithmetic modulo rb_size (masked with rb_size-1).
REQ-011 SHALL write tail[tail_wr_queue] on tail_wr_valid when tail_wr_value < rb_size, and otherwise SHALL drop the write and increment bad_tail_cnt (saturating at 2^32-1).
REQ-012 SHALL treat a queue as pending when tail != issue_head.
REQ-013 SHALL run an FSM with states IDLE, ARB and ISSUE: IDLE->ARB when any queue is pending; ARB->ISSUE after one cycle if outstanding < MAX_OUTSTANDING, otherwise stay in ARB; ISSUE->IDLE on req_valid&req_ready.
REQ-014 SHALL have ARB select the pending queue by round-robin starting at last_granted+1, and if none is pending SHALL return to IDLE.
REQ-015 SHALL compute req_flits = min((tail-issue_head) mod rb_size, MAX_REQ_FLITS, rb_size-issue_head), so that a request never crosses the ring end, and SHALL set req_offset = issue_head.
REQ-016 SHALL register and hold req_* stable while in ISSUE until req_ready is high.
REQ-017 SHALL, on req_valid&req_ready, advance issue_head[q] by req_flits (wrapping to 0 at rb_size) and increment outstanding.
REQ-018 SHALL drive cpl_ready = !head_wb_valid | head_wb_ready.
REQ-019 SHALL, on cpl_valid&cpl_ready, advance done_head[cpl_queue] by cpl_flits (with wrap), decrement outstanding, and register head_wb_valid=1 with the queue id and new done_head on the next cycle.
REQ-020 SHALL hold head_wb_* stable until head_wb_ready is high.
REQ-021 SHALL apply both updates when a doorbell and an issue hit the same queue in the same cycle (tail and issue_head are separate registers), and SHALL use the new tail for that queue from the next ARB onward.
REQ-022 SHALL leave outstanding unchanged when an issue and a completion happen in the same cycle.
REQ-023 SHALL treat a doorbell with tail equal to issue_head as producing no request.
REQ-024 SHALL have a latency of 2 cycles from a doorbell (with the FSM in IDLE) to req_valid.

Reset
REQ-025 SHALL, on rst_n low (asynchronous), clear all tail, issue_head and done_head registers, outstanding, last_granted and bad_tail_cnt, set the FSM to IDLE, and drive req_valid, head_wb_valid and all data outputs to 0.
REQ-026 SHALL discard any request that is mid-handshake when reset asserts, with no replay after reset.

Structure
REQ-027 SHALL place the TX queue-state typedef (tail, issue_head, done_head) and the MAX_REQ_FLITS default in the shared PCIe constants package.
REQ-028 SHALL implement the round-robin selector as the sub-module rr_arbiter (NB_QUEUES request bits, one-hot grant plus index).

Verification
REQ-029 SHALL cover: rb_size=1024, doorbell q3 tail=100 -> one request q3 offset=0 flits=64, then q3 offset=64 flits=36.
REQ-030 SHALL cover: q5 issue_head=1000, doorbell tail=40 -> requests offset=1000 flits=24, then offset=0 flits=40.
REQ-031 SHALL cover: doorbells on q1, q2 and q7 in the same window -> grants in order q1, q2, q7, with no starvation under continuous doorbells.
REQ-032 SHALL cover: 8 requests issued with no completions -> FSM holds in ARB with req_valid=0; one completion -> the 9th request is issued.
REQ-033 SHALL cover: head_wb_ready=0 while 2 completions arrive -> cpl_ready=0 after the first; release -> head_wb values for q0 of 64, then 128.
REQ-034 SHALL cover: doorbell tail=2000 with rb_size=1024 -> no request and bad_tail_cnt=1; rst_n low mid-ISSUE -> req_valid=0 immediately.
